uart_loopback_checker: RTL

Initiator-side self-test engine for the UART echo path. Streams a deterministic byte pattern into a UART transmitter over AXI-Stream, captures each returned byte from a UART receiver, and checks it against the expected echo, which is the sent byte with ASCII letter case inverted. It runs stop-and-wait, with one byte outstanding, and reports pass/fail and error counters. It sits on the host or test FPGA, facing the board under test across a `uart_tx`/`uart_rx` pair.

---
 rtl/uart_loopback_checker.sv | 98 +++++++++
 1 files changed

// File: rtl/uart_loopback_checker.sv
// uart_loopback_checker: stop-and-wait UART echo self-test engine.
// Sends a byte pattern, checks each echo (optionally case-inverted) and keeps saturating error counters.
module uart_loopback_checker #(
  parameter int         CLK_FREQ       = 50000000,
  parameter int         TIMEOUT_CYCLES = CLK_FREQ / 100,
  parameter int         NUM_BYTES      = 256,
  parameter logic [7:0] PATTERN_START  = 8'h20,
  parameter bit         INVERT_CASE    = 1'b1
) (
  input  logic        clk,
  input  logic        sresetn,
  input  logic        start,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] timeout_count,
  output logic [15:0] tx_count,
  output logic [7:0]  last_rx
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] pat_q, pat_d, exp_q, exp_d, last_q, last_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0] tx_q, tx_d, err_q, err_d, to_q, to_d;
  logic go, hs, echo, tmo, adv, fin, alpha, err_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction

  assign go      = (state_q == S_IDLE || state_q == S_DONE) && start;
  assign hs      = state_q == S_SEND && m_axis_tready;
  assign echo    = state_q == S_WAIT && s_axis_tvalid;
  // an echo arriving on the expiry cycle takes priority over the timeout
  assign tmo     = state_q == S_WAIT && !s_axis_tvalid && tmr_q == TW'(TIMEOUT_CYCLES - 1);
  assign adv     = echo || tmo;
  assign fin     = tx_q >= 16'(NUM_BYTES);
  assign alpha   = pat_q inside {[8'h41:8'h5A], [8'h61:8'h7A]};
  assign err_inc = (state_q == S_SEND && s_axis_tvalid) || (echo && s_axis_tdata != exp_q) || tmo;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = go ? S_SEND : hs ? S_WAIT : adv ? (fin ? S_DONE : S_SEND) : state_q;
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      pat_q  <= '0;
      exp_q  <= '0;
      last_q <= '0;
      tmr_q  <= '0;
      tx_q   <= '0;
      err_q  <= '0;
      to_q   <= '0;
    end else begin
      pat_q  <= pat_d;
      exp_q  <= exp_d;
      last_q <= last_d;
      tmr_q  <= tmr_d;
      tx_q   <= tx_d;
      err_q  <= err_d;
      to_q   <= to_d;
    end
  end

  always_comb begin
    pat_d  = go ? PATTERN_START : adv ? pat_q + 8'd1 : pat_q;
    exp_d  = hs ? ((INVERT_CASE && alpha) ? pat_q ^ 8'h20 : pat_q) : exp_q;
    last_d = s_axis_tvalid ? s_axis_tdata : last_q;
    tmr_d  = hs ? '0 : state_q == S_WAIT ? tmr_q + TW'(1) : tmr_q;
    tx_d   = go ? '0 : hs ? sat_inc(tx_q) : tx_q;
    err_d  = go ? '0 : err_inc ? sat_inc(err_q) : err_q;
    to_d   = go ? '0 : tmo ? sat_inc(to_q) : to_q;
  end

  always_comb begin
    m_axis_tvalid = state_q == S_SEND;
    m_axis_tdata  = pat_q;
    busy          = state_q == S_SEND || state_q == S_WAIT;
    done          = state_q == S_DONE;
    pass          = state_q == S_DONE && err_q == '0;
    err_count     = err_q;
    timeout_count = to_q;
    tx_count      = tx_q;
    last_rx       = last_q;
  end
endmodule
